// File: rtl/mux_result_regfile_if.sv
// Bus bundle between the source mux / operand fetch and the writeback register file.
interface mux_result_regfile_if #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned ADDR_W = 4
);
  logic [DATA_W-1:0] MuxOutput;
  logic [3:0]        MuxSelection;
  logic              WriteEn;
  logic [ADDR_W-1:0] WriteAddr;
  logic [ADDR_W-1:0] ReadAddrA;
  logic [ADDR_W-1:0] ReadAddrB;
  logic [DATA_W-1:0] ReadDataA;
  logic [DATA_W-1:0] ReadDataB;
  logic              Pending;
  logic [3:0]        LastSel;
  logic [7:0]        WriteCount;

  modport master (
    output MuxOutput, MuxSelection, WriteEn, WriteAddr, ReadAddrA, ReadAddrB,
    input  ReadDataA, ReadDataB, Pending, LastSel, WriteCount
  );

  modport slave (
    input  MuxOutput, MuxSelection, WriteEn, WriteAddr, ReadAddrA, ReadAddrB,
    output ReadDataA, ReadDataB, Pending, LastSel, WriteCount
  );
endinterface

// File: rtl/mux_result_regfile.sv
// Writeback stage: one-deep write pipeline in front of a register array with
// two forwarding read ports. Register 0 reads as zero.
module mux_result_regfile #(
  parameter int unsigned DATA_W   = 17,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  mux_result_regfile_if.slave  bus
);

  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned CNT_W   = 8;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              pend_q,      pend_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [SEL_W-1:0]  pend_sel_q,  pend_sel_d;
  logic [SEL_W-1:0]  last_sel_q,  last_sel_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              wr_valid_c;

  // Address 0 and unimplemented addresses never enter the pipeline.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGS);
  endfunction

  // Read mux: zero for invalid addresses, pending data when it targets the address.
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    if (!addr_ok(a))                    return '0;
    else if (pend_q && pend_addr_q == a) return pend_data_q;
    else                                 return regs_q[IDX_W'(a)];
  endfunction

  // Next-state for the pipeline stage, last-select and saturating counter.
  always_comb begin
    wr_valid_c  = bus.WriteEn && addr_ok(bus.WriteAddr);
    pend_d      = wr_valid_c;
    pend_data_d = pend_data_q;
    pend_addr_d = pend_addr_q;
    pend_sel_d  = pend_sel_q;
    last_sel_d  = last_sel_q;
    cnt_d       = cnt_q;
    if (wr_valid_c) begin
      pend_data_d = bus.MuxOutput;
      pend_addr_d = bus.WriteAddr;
      pend_sel_d  = bus.MuxSelection;
    end
    if (pend_q) begin
      last_sel_d = pend_sel_q;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline/status registers; reset discards any in-flight write.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_addr_q <= '0;
      pend_sel_q  <= '0;
      last_sel_q  <= '0;
      cnt_q       <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_addr_q <= pend_addr_d;
      pend_sel_q  <= pend_sel_d;
      last_sel_q  <= last_sel_d;
      cnt_q       <= cnt_d;
    end
  end

  // Register array commit from the pending stage.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (pend_q) begin
      regs_q[IDX_W'(pend_addr_q)] <= pend_data_q;
    end
  end

  // Combinational read ports.
  always_comb begin
    bus.ReadDataA = rd(bus.ReadAddrA);
    bus.ReadDataB = rd(bus.ReadAddrB);
  end

  assign bus.Pending    = pend_q;
  assign bus.LastSel    = last_sel_q;
  assign bus.WriteCount = cnt_q;

endmodule
